// File: rtl/rs_enc_ctrl.sv
// Sequencer for the RS(255,239) encoder core: frames bytes into shortened codewords,
// passes data through with zero latency, then emits the first 2*t parity bytes from the core.
module rs_enc_ctrl #(
  parameter int KMAX = 239,
  parameter int TMAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cfg_k,
  input  logic [3:0] cfg_t,
  output logic       cfg_err,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_parity,
  output logic       m_last,
  output logic       core_clr,
  output logic       core_en,
  output logic [7:0] core_din,
  input  logic [7:0] core_par,
  output logic       core_shift,
  output logic       busy
);

  localparam logic [7:0] KMAX_B = 8'(KMAX);
  localparam logic [3:0] TMAX_B = 4'(TMAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] k_q, k_d;
  logic [3:0] t_q, t_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [4:0] pcnt_q, pcnt_d;

  logic       cfg_ok;
  logic       data_end;
  logic       par_end;
  logic [4:0] par_last_idx;

  assign cfg_ok       = (cfg_k != 8'd0) && (cfg_k <= KMAX_B) && (cfg_t <= TMAX_B);
  assign data_end     = (dcnt_q == (k_q - 8'd1)) || s_last;
  // Only meaningful while t_q != 0, which is the only time PARITY is entered.
  assign par_last_idx = {t_q, 1'b0} - 5'd1;
  assign par_end      = (pcnt_q == par_last_idx);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    t_d        = t_q;
    dcnt_d     = dcnt_q;
    pcnt_d     = pcnt_q;
    cfg_err    = 1'b0;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = 8'd0;
    m_parity   = 1'b0;
    m_last     = 1'b0;
    core_clr   = 1'b0;
    core_en    = 1'b0;
    core_din   = 8'd0;
    core_shift = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          if (cfg_ok) begin
            core_clr = 1'b1;
            k_d      = cfg_k;
            t_d      = cfg_t;
            dcnt_d   = 8'd0;
            pcnt_d   = 5'd0;
            state_d  = DATA;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end

      DATA: begin
        m_valid  = s_valid;
        s_ready  = m_ready;
        m_data   = s_data;
        core_din = s_data;
        core_en  = s_valid && m_ready && (t_q != 4'd0);
        m_last   = s_valid && data_end && (t_q == 4'd0);
        if (s_valid && m_ready) begin
          dcnt_d = dcnt_q + 8'd1;
          if (data_end) begin
            state_d = (t_q == 4'd0) ? IDLE : PARITY;
          end
        end
      end

      PARITY: begin
        // core_par only moves on core_shift, so the beat holds under backpressure.
        m_valid    = 1'b1;
        m_data     = core_par;
        m_parity   = 1'b1;
        m_last     = par_end;
        core_shift = m_ready;
        if (m_ready) begin
          pcnt_d = pcnt_q + 5'd1;
          if (par_end) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      cfg_err    = 1'b0;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_data     = 8'd0;
      m_parity   = 1'b0;
      m_last     = 1'b0;
      core_clr   = 1'b0;
      core_en    = 1'b0;
      core_din   = 8'd0;
      core_shift = 1'b0;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 8'd0;
      t_q     <= 4'd0;
      dcnt_q  <= 8'd0;
      pcnt_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

endmodule

// File: doc/rs_enc_ctrl.md
Name: rs_enc_ctrl

Overview:
- Sequencer for the RS(255,239,T=8) GF(2^8) encoder core of the OFDM transmit chain; sits between the randomizer byte stream and the convolutional encoder.
- Frames the byte stream into shortened codewords of cfg_k data bytes.
- Drives the core's clear/feed/shift controls, emits the data bytes systematically, then emits the first 2*cfg_t parity bytes (punctured code).
- cfg_t = 0 is RS bypass.

Parameters:
KMAX, 239, max data bytes per codeword (unshortened K)
TMAX, 8, max correctable symbols; core always holds 2*TMAX parity bytes

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
cfg_k  in  8  data bytes per codeword, legal 1..KMAX; sampled at block start
cfg_t  in  4  parity pairs to emit, legal 0..TMAX; sampled at block start
cfg_err  out  1  high while in IDLE with s_valid=1 and cfg illegal
s_valid  in  1  input byte valid
s_ready  out  1  input byte accepted when s_valid&s_ready
s_data  in  8  input byte
s_last  in  1  last byte of burst (may shorten the final block)
m_valid  out  1  output byte valid
m_ready  in  1  downstream accepts
m_data  out  8  output byte
m_parity  out  1  m_data is a parity byte
m_last  out  1  last byte of the codeword
core_clr  out  1  one-cycle pulse: core parity register := 0
core_en  out  1  core absorbs core_din this cycle (one LFSR byte step)
core_din  out  8  byte to core (= s_data)
core_par  in  8  core's highest-degree parity byte; valid the cycle after the last core_en
core_shift  out  1  core shifts parity register one byte toward core_par, zero fill
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, counters=0. All outputs 0 (s_ready, m_valid, m_data, m_parity, m_last, core_*, busy, cfg_err). Reset mid-block abandons the block; no partial parity is emitted.
- IDLE:
  - s_ready=0. When s_valid=1 and cfg is legal: latch k_r=cfg_k, t_r=cfg_t, drive core_clr=1, go to DATA next cycle.
  - cfg illegal (k=0, k>KMAX, t>TMAX): cfg_err=1, stay IDLE, consume nothing.
  - cfg_k/cfg_t changes after the latch cycle have no effect until the next block.
- DATA (combinational pass-through, zero latency):
  - m_valid=s_valid, s_ready=m_ready, m_data=s_data, m_parity=0.
  - core_en = s_valid&m_ready&(t_r!=0); core_din=s_data.
  - byte counter dcnt increments on each handshake.
  - Last data byte = handshake with dcnt==k_r-1, or with s_last=1 (shortened block; effective k = dcnt+1).
  - On the last byte: t_r==0 → m_last=1 on that byte, next state IDLE. Otherwise m_last=0, next state PARITY.
  - s_last on exactly the k_r-th byte is treated as a normal full block.
- PARITY:
  - s_ready=0, m_valid=1, m_data=core_par, m_parity=1, core_shift=m_ready.
  - pcnt counts accepted parity bytes 0..2*t_r-1; m_last=1 when pcnt==2*t_r-1.
  - After the last parity handshake go to IDLE. The remaining 16-2*t_r core bytes are discarded (cleared by the next core_clr).
  - m_valid stays high under backpressure; m_data remains stable because the core does not shift without core_shift.
- Throughput: one IDLE/clear cycle between codewords; otherwise one byte per cycle when both sides are ready.
- Widths: dcnt 8 bits, pcnt 5 bits, no wrap; k_r ≤ 239 < 256.
- Protocol: m_valid/m_data/m_last must not change while m_valid&!m_ready in PARITY. In DATA they follow s_* and the upstream must hold them.

Test Plan:
- cfg_k=3, cfg_t=2, bytes 0x01,0x02,0x03, m_ready=1 → clr pulse 1 cycle after s_valid. Out: 01,02,03 (m_parity=0), then 4 core_par bytes with m_parity=1; m_last on the 4th parity byte; core_en high 3 cycles, core_shift 4 cycles; total 3+4 output beats.
- cfg_k=239, cfg_t=8, 239 bytes then 100 more → first codeword 255 bytes ending with m_last. One IDLE cycle with s_ready=0 and a second core_clr, then the second block starts.
- cfg_k=10, cfg_t=4, s_last on 6th byte → 6 data + 8 parity bytes, m_last on parity byte 8, back to IDLE.
- cfg_t=0, cfg_k=5 → 5 bytes passed through, m_last on 5th, core_en and core_shift never asserted, m_parity never 1.
- PARITY with m_ready toggling 1,0,0,1 → m_data held during stalls, core_shift only on ready cycles, exactly 2*t parity beats.
- cfg_k=0 or cfg_t=9 with s_valid=1 → cfg_err=1, s_ready=0, no core_clr; fixing cfg starts a block. Reset asserted mid-PARITY → next cycle all outputs 0, state IDLE.
